// File: rtl/hangman_pkg.sv
// Shared key codes, scanner states and multi-tap letter tables for the keypad front end.
package hangman_pkg;

    localparam logic [3:0] KEY_SUBMIT = 4'd12;
    localparam logic [3:0] KEY_CLEAR  = 4'd13;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_PRESS_DB = 2'd1,
        ST_HELD     = 2'd2,
        ST_REL_DB   = 2'd3
    } scan_state_t;

    // Number of letters on a letter key: PQRS and WXYZ carry four, the rest three.
    function automatic logic [2:0] group_size(input logic [2:0] group);
        return (group == 3'd5 || group == 3'd7) ? 3'd4 : 3'd3;
    endfunction

    // ASCII of letter idx within a letter key's group.
    function automatic logic [7:0] tap_letter(input logic [2:0] group, input logic [1:0] idx);
        logic [7:0] base;
        case (group)
            3'd0:    base = 8'h41; // A
            3'd1:    base = 8'h44; // D
            3'd2:    base = 8'h47; // G
            3'd3:    base = 8'h4A; // J
            3'd4:    base = 8'h4D; // M
            3'd5:    base = 8'h50; // P
            3'd6:    base = 8'h54; // T
            default: base = 8'h57; // W
        endcase
        return base + {6'd0, idx};
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// 4x4 matrix scanner: row synchronizer, column rotation and press/release debounce.
//
//   state       | meaning
//   ------------+------------------------------------------------------------
//   ST_SCAN     | rotating col, waiting for any synced row high
//   ST_PRESS_DB | col frozen, confirming the latched row pattern is stable
//   ST_HELD     | press accepted, waiting for all rows low (no auto-repeat)
//   ST_REL_DB   | confirming release; a row coming back returns to ST_HELD
//
// The sample that causes entry into a debounce state counts as its first sample,
// so DEBOUNCE_CYCLES must be at least 2.
module keypad_scanner
    import hangman_pkg::*;
#(
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_event,
    output logic       key_release
);

    localparam int SW = $clog2(SCAN_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    row_s1;
    logic [3:0]    row_sync;
    logic [3:0]    row_latch;
    logic [SW-1:0] scan_cnt;
    logic [DW-1:0] db_cnt;
    logic [1:0]    row_idx;
    logic [1:0]    col_idx;
    scan_state_t   state;

    // Two-flop synchronizer on the asynchronous row lines.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            row_s1   <= 4'b0000;
            row_sync <= 4'b0000;
        end else begin
            row_s1   <= row;
            row_sync <= row_s1;
        end
    end

    // Encode the pressed position; row 0 sits on bit 3 and wins when several rows are high.
    always_comb begin
        row_idx = 2'd3;
        if (row_sync[3])      row_idx = 2'd0;
        else if (row_sync[2]) row_idx = 2'd1;
        else if (row_sync[1]) row_idx = 2'd2;
        case (col)
            4'b0010: col_idx = 2'd1;
            4'b0100: col_idx = 2'd2;
            4'b1000: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    // Scan/debounce state machine; col only moves while scanning.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state       <= ST_SCAN;
            col         <= 4'b0001;
            scan_cnt    <= '0;
            db_cnt      <= '0;
            row_latch   <= 4'b0000;
            key_code    <= 4'd0;
            key_event   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_event   <= 1'b0;
            key_release <= 1'b0;
            case (state)
                ST_SCAN: begin
                    if (row_sync != 4'b0000) begin
                        row_latch <= row_sync;
                        key_code  <= {row_idx, col_idx};
                        db_cnt    <= DW'(1);
                        scan_cnt  <= '0;
                        state     <= ST_PRESS_DB;
                    end else if (scan_cnt == SCAN_LAST) begin
                        scan_cnt <= '0;
                        col      <= {col[2:0], col[3]};
                    end else begin
                        scan_cnt <= scan_cnt + SW'(1);
                    end
                end
                ST_PRESS_DB: begin
                    if (row_sync != row_latch) begin
                        state <= ST_SCAN;
                    end else if (db_cnt == DB_LAST) begin
                        key_event <= 1'b1;
                        state     <= ST_HELD;
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end
                ST_HELD: begin
                    if (row_sync == 4'b0000) begin
                        db_cnt <= DW'(1);
                        state  <= ST_REL_DB;
                    end
                end
                default: begin
                    if (row_sync != 4'b0000) begin
                        state <= ST_HELD;
                    end else if (db_cnt == DB_LAST) begin
                        key_release <= 1'b1;
                        scan_cnt    <= '0;
                        state       <= ST_SCAN;
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/keypad_multitap.sv
// Keypad front end: turns debounced key events into multi-tap letters, letter commits and word submits.
module keypad_multitap
    import hangman_pkg::*;
#(
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int TAP_TIMEOUT     = 300
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [7:0] pending,
    output logic       pending_valid,
    output logic [7:0] letter,
    output logic       letter_strobe,
    output logic       word_strobe
);

    localparam int TW = $clog2(TAP_TIMEOUT + 1);
    localparam logic [TW-1:0] TAP_EXPIRED = TW'(TAP_TIMEOUT);

    logic [3:0]    key_code;
    logic          key_event;
    logic          key_release;
    logic [TW-1:0] tap_timer;
    logic [2:0]    tap_group;
    logic [1:0]    tap_idx;
    logic          is_letter;
    logic          is_submit;
    logic          is_clear;
    logic          same_group;
    logic [2:0]    grp;
    logic [1:0]    next_idx;

    keypad_scanner #(
        .SCAN_CYCLES     (SCAN_CYCLES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_scanner (
        .clk         (clk),
        .nRst        (nRst),
        .row         (row),
        .col         (col),
        .key_code    (key_code),
        .key_event   (key_event),
        .key_release (key_release)
    );

    // Classify the key and work out the next letter within the current group.
    always_comb begin
        grp        = key_code[2:0];
        is_letter  = key_event && !key_code[3];
        is_submit  = key_event && (key_code == KEY_SUBMIT);
        is_clear   = key_event && (key_code == KEY_CLEAR);
        same_group = pending_valid && (tap_group == grp) && (tap_timer != TAP_EXPIRED);
        next_idx   = ({1'b0, tap_idx} == group_size(grp) - 3'd1) ? 2'd0 : tap_idx + 2'd1;
    end

    // Tap timer: restarts on every release, saturates at the timeout; submit/clear force it expired.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            tap_timer <= '0;
        end else if (is_submit || is_clear) begin
            tap_timer <= TAP_EXPIRED;
        end else if (key_release) begin
            tap_timer <= '0;
        end else if (tap_timer != TAP_EXPIRED) begin
            tap_timer <= tap_timer + TW'(1);
        end
    end

    // Pending letter composition, commit and word-submit strobes.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            pending       <= 8'h00;
            pending_valid <= 1'b0;
            letter        <= 8'h00;
            letter_strobe <= 1'b0;
            word_strobe   <= 1'b0;
            tap_group     <= 3'd0;
            tap_idx       <= 2'd0;
        end else begin
            letter_strobe <= 1'b0;
            word_strobe   <= 1'b0;
            if (is_letter) begin
                if (same_group) begin
                    tap_idx <= next_idx;
                    pending <= tap_letter(grp, next_idx);
                end else begin
                    tap_group     <= grp;
                    tap_idx       <= 2'd0;
                    pending       <= tap_letter(grp, 2'd0);
                    pending_valid <= 1'b1;
                end
            end else if (is_submit) begin
                if (pending_valid) begin
                    letter        <= pending;
                    letter_strobe <= 1'b1;
                    pending       <= 8'h00;
                    pending_valid <= 1'b0;
                end else begin
                    word_strobe <= 1'b1;
                end
            end else if (is_clear) begin
                pending       <= 8'h00;
                pending_valid <= 1'b0;
                tap_group     <= 3'd0;
                tap_idx       <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_multitap.sv
// Directed bench for keypad_multitap with a behavioural 4x4 keypad model.
module tb_keypad_multitap;

    logic       clk = 1'b0;
    logic       nRst;
    logic [3:0] row;
    logic [3:0] col;
    logic [7:0] pending;
    logic       pending_valid;
    logic [7:0] letter;
    logic       letter_strobe;
    logic       word_strobe;

    // Keypad model: the pressed key drives its row pattern only while its column is driven.
    logic       key_down = 1'b0;
    logic [3:0] kp = 4'b0000;
    logic [1:0] kc = 2'd0;

    int n_checks = 0;
    int n_pass   = 0;
    int ls_cnt   = 0;
    int ws_cnt   = 0;
    logic [7:0] ls_letter = 8'h00;
    int ls0;
    int ws0;

    keypad_multitap dut (
        .clk           (clk),
        .nRst          (nRst),
        .row           (row),
        .col           (col),
        .pending       (pending),
        .pending_valid (pending_valid),
        .letter        (letter),
        .letter_strobe (letter_strobe),
        .word_strobe   (word_strobe)
    );

    always #5 clk = ~clk;

    assign row = (key_down && col[kc]) ? kp : 4'b0000;

    // Count strobe pulses mid-cycle; each one-cycle pulse is seen exactly once.
    always @(negedge clk) begin
        if (letter_strobe) begin
            ls_cnt    <= ls_cnt + 1;
            ls_letter <= letter;
        end
        if (word_strobe) ws_cnt <= ws_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tap(input logic [3:0] pat, input logic [1:0] c, input int hold);
        kp       = pat;
        kc       = c;
        key_down = 1'b1;
        repeat (hold) @(negedge clk);
        key_down = 1'b0;
        repeat (25) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_col"}, {28'd0, col}, 32'h1);
        chk({tag, "_pending"}, {24'd0, pending}, 32'h00);
        chk({tag, "_pvalid"}, {31'd0, pending_valid}, 32'd0);
        chk({tag, "_letter"}, {24'd0, letter}, 32'h00);
        chk({tag, "_strobes"}, {30'd0, letter_strobe, word_strobe}, 32'd0);
    endtask

    initial begin
        logic [7:0] k5_seq [5];
        k5_seq[0] = 8'h50; k5_seq[1] = 8'h51; k5_seq[2] = 8'h52;
        k5_seq[3] = 8'h53; k5_seq[4] = 8'h50;

        nRst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        nRst = 1'b1;

        // Column rotation every 4 cycles with no key pressed
        repeat (4) @(negedge clk);
        chk("col_1", {28'd0, col}, 32'h2);
        repeat (4) @(negedge clk);
        chk("col_2", {28'd0, col}, 32'h4);
        repeat (4) @(negedge clk);
        chk("col_3", {28'd0, col}, 32'h8);
        repeat (4) @(negedge clk);
        chk("col_0", {28'd0, col}, 32'h1);
        chk("idle_pvalid", {31'd0, pending_valid}, 32'd0);

        // k0 held a long time: one 'A', no auto-repeat
        tap(4'b1000, 2'd0, 200);
        chk("a_pending", {24'd0, pending}, 32'h41);
        chk("a_pvalid", {31'd0, pending_valid}, 32'd1);

        // SUBMIT commits 'A'
        tap(4'b0001, 2'd0, 40);
        chk("sub_ls_cnt", ls_cnt, 32'd1);
        chk("sub_ls_letter", {24'd0, ls_letter}, 32'h41);
        chk("sub_letter", {24'd0, letter}, 32'h41);
        chk("sub_pvalid", {31'd0, pending_valid}, 32'd0);
        chk("sub_pending", {24'd0, pending}, 32'h00);
        chk("sub_ws_cnt", ws_cnt, 32'd0);

        // k5 tapped five times quickly: P Q R S P
        for (int i = 0; i < 5; i++) begin
            tap(4'b0100, 2'd1, 40);
            chk($sformatf("k5_tap%0d", i), {24'd0, pending}, {24'd0, k5_seq[i]});
        end

        // CLEAR drops the pending letter without any strobe
        ls0 = ls_cnt; ws0 = ws_cnt;
        tap(4'b0001, 2'd1, 40);
        chk("clr_pending", {24'd0, pending}, 32'h00);
        chk("clr_pvalid", {31'd0, pending_valid}, 32'd0);
        chk("clr_strobes", ls_cnt - ls0 + ws_cnt - ws0, 32'd0);

        // k1, long pause past the timeout, k1 again: 'D' both times
        tap(4'b1000, 2'd1, 40);
        chk("d_first", {24'd0, pending}, 32'h44);
        repeat (400) @(negedge clk);
        tap(4'b1000, 2'd1, 40);
        chk("d_after_timeout", {24'd0, pending}, 32'h44);

        // CLEAR then SUBMIT with nothing pending: word strobe only
        tap(4'b0001, 2'd1, 40);
        ls0 = ls_cnt; ws0 = ws_cnt;
        tap(4'b0001, 2'd0, 40);
        chk("word_ws", ws_cnt - ws0, 32'd1);
        chk("word_ls", ls_cnt - ls0, 32'd0);

        // 'G' pending, an unassigned key leaves it, CLEAR drops it silently
        tap(4'b1000, 2'd2, 40);
        chk("g_pending", {24'd0, pending}, 32'h47);
        tap(4'b0001, 2'd3, 40);
        chk("k15_ignored", {24'd0, pending}, 32'h47);
        ls0 = ls_cnt; ws0 = ws_cnt;
        tap(4'b0001, 2'd1, 40);
        chk("g_clr_pending", {24'd0, pending}, 32'h00);
        chk("g_clr_strobes", ls_cnt - ls0 + ws_cnt - ws0, 32'd0);

        // Bouncing row: alternating every cycle never gets accepted
        kp = 4'b1000; kc = 2'd0;
        for (int i = 0; i < 20; i++) begin
            key_down = ~key_down;
            @(negedge clk);
        end
        key_down = 1'b0;
        repeat (30) @(negedge clk);
        chk("bounce_pvalid", {31'd0, pending_valid}, 32'd0);
        chk("bounce_pending", {24'd0, pending}, 32'h00);

        // Two rows high on col0: row 0 wins -> 'A'
        tap(4'b1100, 2'd0, 40);
        chk("multirow_pending", {24'd0, pending}, 32'h41);

        // Reset asserted while k2 is held, then released with the key still down
        kp = 4'b1000; kc = 2'd2; key_down = 1'b1;
        repeat (40) @(negedge clk);
        chk("held_pending", {24'd0, pending}, 32'h47);
        nRst = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(negedge clk);
        nRst = 1'b1;
        repeat (40) @(negedge clk);
        chk("fresh_pending", {24'd0, pending}, 32'h47);
        chk("fresh_letter", {24'd0, letter}, 32'h00);
        key_down = 1'b0;
        repeat (25) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_multitap.md
# keypad_multitap

Upstream input stage for the hangman host/player consoles. It scans a 4x4 matrix keypad, synchronizes and debounces the row lines, and converts letter-key presses into phone-style multi-tap ASCII letters. It emits one-cycle strobes for committed letters and for word submission, consumed by the game/message logic in `main`. One instance sits on the host keypad and one on the player keypad.

## Interface
- `SCAN_CYCLES`, 4: clock cycles each column stays driven while scanning.
- `DEBOUNCE_CYCLES`, 3: consecutive identical synchronized samples required to accept a press or a release.
- `TAP_TIMEOUT`, 300: cycles after a release within which the same letter key advances the pending letter.
- `clk` in 1: system clock, single clock domain.
- `nRst` in 1: asynchronous, active-low reset.
- `row` in 4: keypad rows, active-high; bit 3 = row 0, bit 0 = row 3.
- `col` out 4: one-hot column drive; bit 0 = column 0.
- `pending` out 8: ASCII of the letter being composed; 8'h00 when none.
- `pending_valid` out 1: a pending letter exists.
- `letter` out 8: ASCII of the last committed letter; holds until the next commit.
- `letter_strobe` out 1: one-cycle pulse; `letter` is valid in the same cycle.
- `word_strobe` out 1: one-cycle pulse; submit was pressed with no pending letter.

## Operation
- Key code k = 4*r + c, where r is the row index and c is the driven column.
- Letter keys and their groups:
  - k0 ABC, k1 DEF, k2 GHI, k3 JKL
  - k4 MNO, k5 PQRS, k6 TUV, k7 WXYZ
- k12 = SUBMIT (row 3, column 0); k13 = CLEAR; all other keys are accepted and then ignored.
- Each row bit passes through a 2-flop synchronizer before use.
- Scanner FSM states:
  - SCAN: rotate `col` (0001→0010→0100→1000→0001) every SCAN_CYCLES. Any nonzero synced row → latch k and go to PRESS_DB; `col` freezes.
  - PRESS_DB: same row pattern for DEBOUNCE_CYCLES samples → emit key event, go to HELD. A mismatch → SCAN; the scan counter restarts.
  - HELD: wait for synced rows == 0, then go to REL_DB.
  - REL_DB: rows == 0 for DEBOUNCE_CYCLES → SCAN, arm the tap timer. A nonzero sample → HELD.
- Multiple rows high: the lowest row index wins (highest bit set).
- Letter key event:
  - Same group as pending and tap timer not expired → advance within the group, wrapping (S→P, Z→W, C→A).
  - Otherwise → pending = first letter of the group; the previous pending letter is discarded.
- SUBMIT event:
  - With `pending_valid`: `letter` = `pending`, pulse `letter_strobe`, clear `pending`.
  - Without `pending_valid`: pulse `word_strobe`.
- CLEAR event: clear `pending` and the tap group. No strobe.
- Tap timer: counts up from release and saturates at TAP_TIMEOUT (expired). A SUBMIT or CLEAR event expires it.
- Letters are uppercase ASCII 8'h41–8'h5A.

## Timing
- Reset values: `col` = 4'b0001; `pending` = 8'h00; `pending_valid` = 0; `letter` = 8'h00; both strobes 0; FSM in SCAN; all counters 0.
- Row-to-acceptance latency: 2 synchronizer cycles plus DEBOUNCE_CYCLES.
- `pending`, `pending_valid` and the strobes update in the cycle after the key event (registered outputs).
- A strobe fires once per accepted press, never on release or while held.
- A held key never auto-repeats.
- Reset asserted mid-press: everything returns to reset values immediately. A key still held after reset release is accepted as a fresh press.
- Tap timer at exactly TAP_TIMEOUT counts as expired: the same key restarts at the first letter of its group.

## Structure
- `hangman_pkg` holds:
  - key-code localparams (`KEY_SUBMIT` = 12, `KEY_CLEAR` = 13);
  - the scanner state enum;
  - function `tap_letter(group, idx)` returning ASCII;
  - group sizes (3, or 4 for PQRS/WXYZ).
- Sub-module `keypad_scanner` owns the synchronizer, column rotation and debounce FSM, and outputs `key_code[3:0]` and a one-cycle `key_event`.
- `keypad_multitap` instantiates it and owns the multi-tap, commit and timer logic.

## Test plan
- Reset, rows 0: `col` cycles 0001→0010→0100→1000 every 4 cycles; all outputs stay at reset values.
- Row 4'b1000 while col0 is driven, for 10 cycles, then release: `pending` = 8'h41 ('A'), `pending_valid` = 1. Then SUBMIT (row 4'b0001 on col0): `letter_strobe` pulses once with `letter` = 8'h41, and `pending_valid` drops.
- k5 tapped 5 times, each within 300 cycles: `pending` sequence P, Q, R, S, P (wrap).
- k1 tapped, wait 400 cycles, k1 tapped again: `pending` = 'D' both times (timeout).
- SUBMIT with nothing pending: `word_strobe` pulses once, `letter_strobe` stays 0. CLEAR after 'G' pending: `pending` = 8'h00 and no strobe.
- Row bouncing 1/0 on alternate cycles for 20 cycles: no key event. `nRst` pulsed while in HELD: outputs return to reset values asynchronously.
